// File: rtl/mesm6_mem_arbiter_pkg.sv
// mesm6_arb_pkg: shared types for the MESM-6 memory arbiter.
// Optional round-robin tie-break is enabled by defining MESM6_ARB_RR_EN.
package mesm6_arb_pkg;

  localparam int ARB_ADDR_W = 15;
  localparam int ARB_DATA_W = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_t;

endpackage

// File: rtl/mesm6_mem_arbiter_if.sv
// mesm6_mem_arbiter_if: core instruction/data buses plus the memory-controller
// side of the arbiter. The arbiter uses the master view: it serves the core
// buses and masters the single memory port. The slave view is the environment
// (core and memory controller) around it.
interface mesm6_mem_arbiter_if #(
  parameter int ADDR_W = mesm6_arb_pkg::ARB_ADDR_W,
  parameter int DATA_W = mesm6_arb_pkg::ARB_DATA_W
) ();

  logic              ibus_fetch;
  logic [ADDR_W-1:0] ibus_addr;
  logic [DATA_W-1:0] ibus_input;
  logic              ibus_done;

  logic              dbus_read;
  logic              dbus_write;
  logic [ADDR_W-1:0] dbus_addr;
  logic [DATA_W-1:0] dbus_output;
  logic [DATA_W-1:0] dbus_input;
  logic              dbus_done;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  ibus_fetch, ibus_addr,
    input  dbus_read, dbus_write, dbus_addr, dbus_output,
    input  mem_rdata, mem_ack,
    output ibus_input, ibus_done,
    output dbus_input, dbus_done,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output ibus_fetch, ibus_addr,
    output dbus_read, dbus_write, dbus_addr, dbus_output,
    output mem_rdata, mem_ack,
    input  ibus_input, ibus_done,
    input  dbus_input, dbus_done,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mesm6_mem_arbiter_pick.sv
// mesm6_arb_pick: combinational grant selection between ibus and dbus.
// A masked port is ignored. Ties go to dbus, or with MESM6_ARB_RR_EN defined,
// to the port that was not granted last.
module mesm6_arb_pick
  import mesm6_arb_pkg::*;
(
  input  logic      req_i,
  input  logic      req_d,
  input  logic      mask_i,
  input  logic      mask_d,
`ifdef MESM6_ARB_RR_EN
  input  arb_port_t last_grant,
`endif
  output logic      grant_valid,
  output arb_port_t grant_port
);

  logic eligible_i;
  logic eligible_d;

  assign eligible_i = req_i & ~mask_i;
  assign eligible_d = req_d & ~mask_d;

  // Select the winning port among the eligible requests.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant_valid = eligible_i | eligible_d;
    grant_port  = PORT_D;
    if (eligible_i && eligible_d) begin
`ifdef MESM6_ARB_RR_EN
      grant_port = (last_grant == PORT_D) ? PORT_I : PORT_D;
`else
      grant_port = PORT_D;
`endif
    end else if (eligible_i) begin
      grant_port = PORT_I;
    end
  end

endmodule

// File: rtl/mesm6_mem_arbiter.sv
// mesm6_mem_arbiter: shares one single-ported 48-bit memory between the
// MESM-6 instruction and data buses. One transfer at a time; each served port
// gets a one-cycle done pulse and its stale request is masked for the next
// IDLE cycle. Define MESM6_ARB_RR_EN for round-robin on simultaneous requests;
// otherwise dbus has fixed priority.
module mesm6_mem_arbiter
  import mesm6_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input logic                 clk,
  input logic                 reset_n,
  mesm6_mem_arbiter_if.master bus
);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic              mask_i_q;
  logic              mask_d_q;
  logic              grant_valid;
  arb_port_t         grant_port;
  logic              grant;
  logic              dbus_req;
  logic              ack_i;
  logic              ack_d;

  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] ibus_input_q;
  logic [DATA_W-1:0] dbus_input_q;
  logic              ibus_done_q;
  logic              dbus_done_q;

`ifdef MESM6_ARB_RR_EN
  arb_port_t         last_grant_q;
`endif

  // A simultaneous read and write on dbus is a write.
  assign dbus_req = bus.dbus_read | bus.dbus_write;
  assign grant    = (state_q == IDLE) && grant_valid;
  assign ack_i    = (state_q == BUS_I) && bus.mem_ack;
  assign ack_d    = (state_q == BUS_D) && bus.mem_ack;

  mesm6_arb_pick u_pick (
    .req_i       (bus.ibus_fetch),
    .req_d       (dbus_req),
    .mask_i      (mask_i_q),
    .mask_d      (mask_d_q),
`ifdef MESM6_ARB_RR_EN
    .last_grant  (last_grant_q),
`endif
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  // Next-state logic: grant from IDLE, wait for ack, one DONE cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_valid) state_d = (grant_port == PORT_D) ? BUS_D : BUS_I;
      BUS_I,
      BUS_D:   if (bus.mem_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Request, done pulses and stale-request masks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_q   <= 1'b0;
      ibus_done_q <= 1'b0;
      dbus_done_q <= 1'b0;
      mask_i_q    <= 1'b0;
      mask_d_q    <= 1'b0;
    end else begin
      if (grant)             mem_req_q <= 1'b1;
      else if (ack_i | ack_d) mem_req_q <= 1'b0;
      ibus_done_q <= ack_i;
      dbus_done_q <= ack_d;
      // The done pulse of a port masks that port for exactly the next cycle.
      mask_i_q    <= ibus_done_q;
      mask_d_q    <= dbus_done_q;
    end
  end

  // Memory-side address/data registers, latched at grant and held through the transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: data registers are reset too, because their outputs must read 0 after reset.
    if (!reset_n) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (grant) begin
      mem_we_q   <= (grant_port == PORT_D) && bus.dbus_write;
      mem_addr_q <= (grant_port == PORT_D) ? bus.dbus_addr : bus.ibus_addr;
      if ((grant_port == PORT_D) && bus.dbus_write) mem_wdata_q <= bus.dbus_output;
    end
  end

  // Read-data registers: updated only by a read on the same port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ibus_input_q <= '0;
      dbus_input_q <= '0;
    end else begin
      if (ack_i)              ibus_input_q <= bus.mem_rdata;
      if (ack_d && !mem_we_q) dbus_input_q <= bus.mem_rdata;
    end
  end

`ifdef MESM6_ARB_RR_EN
  // Remember the last granted port for the round-robin tie-break.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   last_grant_q <= PORT_I;
    else if (grant) last_grant_q <= grant_port;
  end
`endif

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.ibus_input = ibus_input_q;
  assign bus.ibus_done  = ibus_done_q;
  assign bus.dbus_input = dbus_input_q;
  assign bus.dbus_done  = dbus_done_q;

endmodule

// File: doc/mesm6_mem_arbiter.md
# mesm6_mem_arbiter

Shares a single-ported 48-bit main memory between the MESM-6 core's instruction bus (`ibus_*`) and data bus (`dbus_*`). It sits between `mesm6_core` and the memory controller, serializes the two request streams, and returns one-cycle `*_done` pulses with registered read data. Because the core holds each request for one cycle after `done`, the arbiter masks that stale request so a transfer is never issued twice.

## Interface
- `ADDR_W`, 15: word address width
- `DATA_W`, 48: word width
- `clk` in 1: clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `ibus_fetch` in 1: instruction fetch request, level-held
- `ibus_addr` in ADDR_W: fetch address
- `ibus_input` out DATA_W: fetched word, registered
- `ibus_done` out 1: one-cycle completion pulse
- `dbus_read` in 1: data read request, level-held
- `dbus_write` in 1: data write request, level-held
- `dbus_addr` in ADDR_W: data address
- `dbus_output` in DATA_W: write data from core
- `dbus_input` out DATA_W: read word, registered
- `dbus_done` out 1: one-cycle completion pulse
- `mem_req` out 1: memory request, held until ack
- `mem_we` out 1: 1 = write, 0 = read
- `mem_addr` out ADDR_W: memory address
- `mem_wdata` out DATA_W: write data
- `mem_rdata` in DATA_W: read data, valid with `mem_ack`
- `mem_ack` in 1: one-cycle acknowledge, earliest in the first `mem_req` cycle

## Operation
- FSM states: IDLE, BUS_I, BUS_D, DONE.
- IDLE: evaluate unmasked requests.
  - Grant goes to BUS_D or BUS_I.
  - Address, write enable and write data are latched into registers driving the `mem_*` outputs.
- BUS_I / BUS_D: `mem_req`=1.
  - On `mem_ack`: capture `mem_rdata` into `ibus_input` or `dbus_input`. Reads only; writes leave `dbus_input` unchanged.
  - Next state DONE.
- DONE: assert the served port's `*_done` for exactly 1 cycle. Next state IDLE with the served port masked for that one IDLE cycle.
- Mask: a served port's request is ignored in the first IDLE cycle after DONE. The other port may be granted in that cycle.
- Simultaneous requests: `dbus` wins unless configured otherwise (see Configuration).
- `dbus_read` and `dbus_write` both high: treated as a write.
- Request dropped while in BUS_*: the transfer still completes and `done` is still pulsed.
- `ibus_input` and `dbus_input` hold their values until the next read on the same port.

## Timing
- Minimum latency: request seen in IDLE at cycle 0 → `mem_req` at cycle 1 → ack at cycle 1 → `done` at cycle 2.
- Back-to-back on the same port: the next grant is at cycle 4 or later because of the one-cycle mask.
- Memory-side outputs are registered. `mem_addr`, `mem_we` and `mem_wdata` are stable throughout `mem_req`.
- Reset (asynchronous, any state, including mid-transfer):
  - State → IDLE, masks cleared.
  - `mem_req`, `mem_we`, `ibus_done`, `dbus_done` → 0.
  - `mem_addr`, `mem_wdata`, `ibus_input`, `dbus_input` → 0.
  - A pending ack after reset is ignored.

## Configuration
- `MESM6_ARB_RR_EN` defined: round-robin when both ports request in the same IDLE cycle.
  - A 1-bit `last_grant` register selects the port not served last.
  - `last_grant` resets to "ibus served" so the first tie goes to dbus.
- `MESM6_ARB_RR_EN` undefined: fixed priority, dbus over ibus. There is no `last_grant` register.

## Structure
- Package `mesm6_arb_pkg`:
  - `arb_state_t` enum (IDLE, BUS_I, BUS_D, DONE)
  - `arb_port_t` enum (PORT_I, PORT_D)
- Sub-module `mesm6_arb_pick`: combinational grant selection from the two requests, the masks and, under the macro, `last_grant`. Output is a grant-valid signal plus the selected port.
- The FSM, address/data registers and read-data registers live in the top module.

## Test plan
- Single fetch: `ibus_fetch`=1 with addr 0o00100; memory acks in the first cycle with 0x123456789ABC → `mem_req` at cycle 1; `ibus_done` at cycle 2; `ibus_input`=0x123456789ABC.
- Write: `dbus_write` with addr 0o77777 and data 0xFFFF00000001; ack delayed 3 cycles → `mem_we`=1 and stable data for 3 `mem_req` cycles; one `dbus_done` pulse; `dbus_input` unchanged.
- Stale-request mask: the core keeps `ibus_fetch` high 1 cycle after `ibus_done` → exactly one memory transaction.
- Simultaneous `ibus_fetch` and `dbus_read`, held for 4 transfers:
  - Fixed mode: dbus is granted first, then ibus in the masked cycle.
  - `MESM6_ARB_RR_EN` mode: grant order D, I, D, I.
- Reset mid-transfer: assert `reset_n`=0 during BUS_D → all outputs 0 immediately; a later `mem_ack` produces no `done`.
